// File: rtl/stack_pkg.sv
// Shared definitions for the stack and its unloader: entry width and depth
// defaults, the unloader state encoding and a counter-width helper.
// The CSUM state exists only when STACK_UNLOADER_CHECKSUM_EN is defined.
package stack_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

`ifdef STACK_UNLOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_CSUM    = 3'd4,
    ST_DONE    = 3'd5
  } unload_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd5
  } unload_state_e;
`endif

  // Counter wide enough to hold DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_unloader_if.sv
// Output stream of the stack unloader: valid/ready handshake with data and
// an end-of-drain marker. master drives the stream, slave consumes it.
interface stack_unloader_if
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/stack_unloader.sv
// stack_unloader: pops entries from a stack one at a time and streams them
// out over a valid/ready handshake, stopping after req_count entries or when
// the stack runs empty (req_count of 0, or above DEPTH, means until empty).
// Optional feature: define STACK_UNLOADER_CHECKSUM_EN to append one extra
// beat carrying the XOR of all data beats; that beat then carries out_last.
module stack_unloader
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   req_count,
  input  logic               stk_empty,
  input  logic [DATA_W-1:0]  stk_data,
  output logic               stk_pop,
  stack_unloader_if.master   out_if,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   item_count
);

  unload_state_e     state_q, state_d;
  logic [CNT_W-1:0]  req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  item_count_q, item_count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              last_q, last_d;
  logic              stk_pop_q, stk_pop_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
`ifdef STACK_UNLOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  cnt_sat;
  logic              last_now;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign cnt_sat  = (cnt_q >= CNT_W'(DEPTH)) ? cnt_q : cnt_inc;
  // stk_empty here already reflects the pop that produced stk_data.
  assign last_now = ((req_q != '0) && (cnt_inc == req_q)) || stk_empty;

  // Next-state and next-output logic for the drain sequencer.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    item_count_d = item_count_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    last_d       = last_q;
    stk_pop_d    = 1'b0;
    done_d       = 1'b0;
`ifdef STACK_UNLOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Requests larger than DEPTH fall back to drain-until-empty.
          req_d = (req_count > CNT_W'(DEPTH)) ? '0 : req_count;
          cnt_d = '0;
`ifdef STACK_UNLOADER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (!stk_empty) begin
            state_d   = ST_POP;
            stk_pop_d = 1'b1;
          end else begin
            state_d      = ST_DONE;
            done_d       = 1'b1;
            item_count_d = '0;
          end
        end
      end
      ST_POP: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        out_data_d  = stk_data;
        out_valid_d = 1'b1;
        last_d      = last_now;
`ifdef STACK_UNLOADER_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = last_now;
`endif
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_if.out_ready) begin
          cnt_d       = cnt_sat;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
`ifdef STACK_UNLOADER_CHECKSUM_EN
          csum_d      = csum_q ^ out_data_q;
`endif
          if (last_q) begin
`ifdef STACK_UNLOADER_CHECKSUM_EN
            state_d     = ST_CSUM;
            out_data_d  = csum_q ^ out_data_q;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
`else
            state_d      = ST_DONE;
            done_d       = 1'b1;
            item_count_d = cnt_sat;
`endif
          end else if (stk_empty) begin
            // Guard: never pop an empty stack, even if it drained unexpectedly.
            state_d      = ST_DONE;
            done_d       = 1'b1;
            item_count_d = cnt_sat;
          end else begin
            state_d   = ST_POP;
            stk_pop_d = 1'b1;
          end
        end
      end
`ifdef STACK_UNLOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (out_if.out_ready) begin
          out_valid_d  = 1'b0;
          out_last_d   = 1'b0;
          state_d      = ST_DONE;
          done_d       = 1'b1;
          item_count_d = cnt_q;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; asynchronous active-low reset clears all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      item_count_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      last_q       <= 1'b0;
      stk_pop_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef STACK_UNLOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      item_count_q <= item_count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      last_q       <= last_d;
      stk_pop_q    <= stk_pop_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
`ifdef STACK_UNLOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign stk_pop          = stk_pop_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign item_count       = item_count_q;

endmodule

// File: tb/tb_stack_unloader.sv
// Testbench for stack_unloader: a behavioural stack feeds the DUT, a monitor
// records the output stream, and each drain is compared against the entries
// the stack model says should come out, newest first.
module tb_stack_unloader;
  import stack_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef STACK_UNLOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] req_count = '0;
  logic          stk_empty;
  logic [DW-1:0] stk_data = '0;
  logic          stk_pop;
  logic          busy;
  logic          done;
  logic [CW-1:0] item_count;

  stack_unloader_if #(.DATA_W(DW)) out_if ();

  stack_unloader #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .req_count  (req_count),
    .stk_empty  (stk_empty),
    .stk_data   (stk_data),
    .stk_pop    (stk_pop),
    .out_if     (out_if),
    .busy       (busy),
    .done       (done),
    .item_count (item_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- stack model ----------------
  logic [DW-1:0] mem [64];
  int            sp = 0;
  logic          push_en = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] push_val = '0;

  assign stk_empty = (sp == 0);

  always @(posedge clk) begin
    if (clr) sp <= 0;
    else if (push_en) begin
      mem[sp] <= push_val;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_data <= mem[sp-1];
      sp       <= sp - 1;
    end
  end

  task automatic push(input logic [DW-1:0] v);
    push_en = 1'b1; push_val = v;
    @(posedge clk); #1;
    push_en = 1'b0;
  endtask

  task automatic clear_stack();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // ---------------- ready driver ----------------
  int ready_mode = 0;   // 0 always ready, 1 random, 2 stall 4 cycles once, 3 never
  int stall_cnt  = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: out_if.out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (out_if.out_valid && stall_cnt < 4) begin
          out_if.out_ready = 1'b0;
          stall_cnt = stall_cnt + 1;
        end else out_if.out_ready = 1'b1;
      end
      3: out_if.out_ready = 1'b0;
      default: begin
        out_if.out_ready = 1'b1;
        stall_cnt = 0;
      end
    endcase
  end

  // ---------------- monitor ----------------
  logic [DW-1:0] beat_d [$];
  logic          beat_l [$];
  int            pops = 0, dones = 0, stalls = 0;
  int            viol_empty = 0, viol_popsend = 0, viol_stable = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  always @(negedge clk) begin
    if (!rst) stall_prev <= 1'b0;
    else begin
      if (stk_pop) pops <= pops + 1;
      if (stk_pop && stk_empty) viol_empty <= viol_empty + 1;
      if (stk_pop && out_if.out_valid) viol_popsend <= viol_popsend + 1;
      if (done) dones <= dones + 1;
      if (out_if.out_valid && !out_if.out_ready) stalls <= stalls + 1;
      if (stall_prev && out_if.out_valid &&
          (out_if.out_data != stall_data || out_if.out_last != stall_last))
        viol_stable <= viol_stable + 1;
      if (out_if.out_valid && out_if.out_ready) begin
        beat_d.push_back(out_if.out_data);
        beat_l.push_back(out_if.out_last);
      end
      stall_prev <= out_if.out_valid && !out_if.out_ready;
      stall_data <= out_if.out_data;
      stall_last <= out_if.out_last;
    end
  end

  // ---------------- drain and compare ----------------
  task automatic pulse_start(input logic [CW-1:0] req);
    @(posedge clk); #1;
    start = 1'b1; req_count = req;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_drain(input logic [CW-1:0] req, input int mode, input bit poke,
                          input bit lat, input int exp_stalls);
    logic [DW-1:0] expd [$];
    logic [DW-1:0] x;
    int n, sp0, pops0, b0, dn0, st0, ve0, vp0, vs0, cyc, nb, enb;
    bit got_done;
    sp0 = sp;
    n = (req == 0 || req > CW'(DEPTH)) ? sp0 : ((int'(req) < sp0) ? int'(req) : sp0);
    x = '0;
    for (int i = 0; i < n; i++) begin
      expd.push_back(mem[sp0-1-i]);
      x = x ^ mem[sp0-1-i];
    end
    if (CSUM_EN && n > 0) expd.push_back(x);
    pops0 = pops; b0 = beat_d.size(); dn0 = dones; st0 = stalls;
    ve0 = viol_empty; vp0 = viol_popsend; vs0 = viol_stable;
    ready_mode = mode;
    pulse_start(req);
    got_done = 1'b0; cyc = 0;
    for (int c = 1; c <= 400 && !got_done; c++) begin
      @(negedge clk);
      if (poke) begin
        if (c == 2) begin start = 1'b1; req_count = CW'(1); end
        else if (c == 3) start = 1'b0;
      end
      if (lat) begin
        case (c)
          1: begin check("lat_pop_n1", stk_pop, 1); check("lat_vld_n1", out_if.out_valid, 0); end
          2: begin check("lat_pop_n2", stk_pop, 0); check("lat_vld_n2", out_if.out_valid, 0); end
          3: check("lat_vld_n3", out_if.out_valid, 1);
          4: begin check("lat_pop_b2", stk_pop, 1); check("lat_vld_b2", out_if.out_valid, 0); end
          5: check("lat_vld_b2c", out_if.out_valid, 0);
          6: check("lat_vld_b2s", out_if.out_valid, 1);
          default: ;
        endcase
      end
      if (done) begin got_done = 1'b1; cyc = c; end
    end
    check("done_seen", got_done, 1);
    if (got_done) begin
      check("item_count", item_count, n);
      check("busy_in_done", busy, 1);
      if (n == 0) check("empty_done_lat", cyc, 1);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    ready_mode = 0;
    nb  = beat_d.size() - b0;
    enb = expd.size();
    check("beat_count", nb, enb);
    for (int i = 0; i < nb && i < enb; i++) begin
      check("beat_data", beat_d[b0+i], expd[i]);
      check("beat_last", beat_l[b0+i], (i == enb - 1) ? 1 : 0);
    end
    check("pop_count", pops - pops0, n);
    check("stack_left", sp, sp0 - n);
    check("done_pulses", dones - dn0, 1);
    check("pop_when_empty", viol_empty - ve0, 0);
    check("pop_during_send", viol_popsend - vp0, 0);
    check("data_stable", viol_stable - vs0, 0);
    if (exp_stalls >= 0) check("stall_cycles", stalls - st0, exp_stalls);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dn0, k, rs;
    bit seen;
    logic [CW-1:0] rq;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_pop", stk_pop, 0);
    check("rst_valid", out_if.out_valid, 0);
    check("rst_last", out_if.out_last, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_if.out_data, 0);
    check("rst_item_count", item_count, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    // Three entries drained until empty, with latency checks
    clear_stack();
    push(8'h11); push(8'h22); push(8'h33);
    do_drain(CW'(0), 0, 1'b0, 1'b1, 0);

    // Partial drain of five entries
    clear_stack();
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    do_drain(CW'(2), 0, 1'b0, 1'b0, 0);

    // Empty stack
    clear_stack();
    do_drain(CW'(0), 0, 1'b0, 1'b0, 0);

    // Back-pressure on the first beat
    clear_stack();
    push(8'h5A); push(8'hC3); push(8'h0F);
    do_drain(CW'(0), 2, 1'b0, 1'b0, 4);

    // Start while busy is ignored
    clear_stack();
    for (int i = 0; i < 4; i++) push(8'h90 + 8'(i));
    do_drain(CW'(3), 0, 1'b1, 1'b0, 0);

    // Oversized request drains until empty
    clear_stack();
    for (int i = 0; i < 6; i++) push(8'hE0 + 8'(i));
    do_drain(CW'(20), 0, 1'b0, 1'b0, 0);

    // Reset in SEND abandons the drain
    clear_stack();
    push(8'hA1); push(8'hA2); push(8'hA3);
    dn0 = dones;
    ready_mode = 3;
    pulse_start(CW'(0));
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (out_if.out_valid) seen = 1'b1;
    end
    check("reach_send", seen, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", out_if.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pop", stk_pop, 0);
    check("mid_rst_last", out_if.out_last, 0);
    check("mid_rst_data", out_if.out_data, 0);
    #1 rst = 1'b1;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", dones - dn0, 0);
    check("mid_rst_left", sp, 2);
    do_drain(CW'(0), 0, 1'b0, 1'b0, 0);

    // Randomized drains
    for (int it = 0; it < 12; it++) begin
      if (sp > 40) clear_stack();
      k = $urandom_range(0, 5);
      for (int i = 0; i < k; i++) push(8'($urandom));
      rs = $urandom_range(0, 3);
      rq = (rs == 0) ? CW'(0) : (rs == 1) ? CW'(20) : CW'($urandom_range(1, 7));
      do_drain(rq, $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
